// File: rtl/alu_mul_sequencer_if.sv
// rtl/alu_mul_sequencer_if.sv - request/response handshake and ALU bus of the multiply sequencer
interface alu_mul_sequencer_if;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        in_ready;
    logic [31:0] result;
    logic        out_valid;
    logic        out_ready;
    logic        alu_en;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_result;

    modport slave (
        input  start, op_a, op_b, out_ready, alu_result,
        output in_ready, result, out_valid, alu_en, alu_a, alu_b, alu_ctrl
    );

    modport master (
        output start, op_a, op_b, out_ready, alu_result,
        input  in_ready, result, out_valid, alu_en, alu_a, alu_b, alu_ctrl
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - shift-and-add 32x32 low-word multiply sequenced through the shared ALU
module alu_mul_sequencer (
    input  logic              clk,
    input  logic              rst_n,
    alu_mul_sequencer_if.slave bus
);
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SHL = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] p_q, p_d;
    logic [31:0] m_q, m_d;
    logic [31:0] q_q, q_d;

    logic        in_ready_c;
    logic        out_valid_c;
    logic [31:0] result_c;
    logic        alu_en_c;
    logic [31:0] alu_a_c;
    logic [31:0] alu_b_c;
    logic [2:0]  alu_ctrl_c;

    // state, product, shifted multiplicand and remaining multiplier registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            m_q     <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            m_q     <= m_d;
            q_q     <= q_d;
        end
    end

    // next state, register updates from the ALU result, and ALU/handshake drive
    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        m_d         = m_q;
        q_d         = q_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        result_c    = '0;
        alu_en_c    = 1'b0;
        alu_a_c     = '0;
        alu_b_c     = '0;
        alu_ctrl_c  = ALU_ADD;

        case (state_q)
            S_IDLE: begin
                in_ready_c = 1'b1;
                if (bus.start) begin
                    p_d     = '0;
                    m_d     = bus.op_a;
                    q_d     = bus.op_b;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                alu_en_c   = 1'b1;
                alu_a_c    = p_q;
                alu_b_c    = m_q;
                alu_ctrl_c = ALU_ADD;
                // no set bits left in the multiplier: the product is final
                if (q_q == 32'd0) begin
                    state_d = S_DONE;
                end else begin
                    if (q_q[0]) begin
                        p_d = bus.alu_result;
                    end
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                alu_en_c   = 1'b1;
                alu_a_c    = m_q;
                alu_b_c    = 32'd1;
                alu_ctrl_c = ALU_SHL;
                m_d        = bus.alu_result;
                q_d        = q_q >> 1;
                state_d    = S_ADD;
            end
            S_DONE: begin
                out_valid_c = 1'b1;
                result_c    = p_q;
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.result    = result_c;
    assign bus.alu_en    = alu_en_c;
    assign bus.alu_a     = alu_a_c;
    assign bus.alu_b     = alu_b_c;
    assign bus.alu_ctrl  = alu_ctrl_c;
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb/tb_alu_mul_sequencer.sv - directed and randomized checks of the multiply sequencer against an ALU model
module tb_alu_mul_sequencer;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    alu_mul_sequencer_if bus ();

    alu_mul_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // combinational core ALU: 000 add, 001 shift-left
    assign bus.alu_result = (bus.alu_ctrl == 3'b001) ? (bus.alu_a << bus.alu_b[4:0])
                                                     : (bus.alu_a + bus.alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int bit_len(input logic [31:0] v);
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) return i + 1;
        end
        return 0;
    endfunction

    // alu_ctrl must only ever show add or shift-left
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            n_checks++;
            assert (bus.alu_ctrl === 3'b000 || bus.alu_ctrl === 3'b001) else begin
                n_fails++;
                $error("FAIL alu_ctrl_range observed=%b expected=000/001", bus.alu_ctrl);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check32({tag, "_in_ready"},  {31'd0, bus.in_ready},  32'd1);
        check32({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        check32({tag, "_result"},    bus.result,             32'd0);
        check32({tag, "_alu_en"},    {31'd0, bus.alu_en},    32'd0);
        check32({tag, "_alu_a"},     bus.alu_a,              32'd0);
        check32({tag, "_alu_b"},     bus.alu_b,              32'd0);
        check32({tag, "_alu_ctrl"},  {29'd0, bus.alu_ctrl},  32'd0);
    endtask

    // entered at a negedge with the block idle; returns at a negedge with the block idle again
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int stall,
                          input bit poke, input bit full, input string tag);
        int          lat;
        int          shifts;
        int          n;
        logic [31:0] prod;
        n    = bit_len(b);
        prod = a * b;
        check32({tag, "_idle_ready"}, {31'd0, bus.in_ready}, 32'd1);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        @(posedge clk);
        @(negedge clk);
        if (poke) begin
            bus.op_a = ~a;
            bus.op_b = 32'hFFFF_FFFF;
        end else begin
            bus.start = 1'b0;
        end
        lat    = 0;
        shifts = 0;
        while (bus.out_valid !== 1'b1) begin
            if (full) begin
                check32({tag, "_busy_alu_en"},   {31'd0, bus.alu_en},   32'd1);
                check32({tag, "_busy_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
            end
            if (bus.alu_ctrl === 3'b001) shifts++;
            if (lat >= 100) begin
                n_checks++;
                n_fails++;
                $error("FAIL %s_timeout observed=no out_valid after %0d edges expected=%0d", tag, lat, 2 * n + 1);
                bus.start = 1'b0;
                return;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check32({tag, "_latency"}, lat, 2 * n + 1);
        check32({tag, "_shifts"},  shifts, n);
        check32({tag, "_result"},  bus.result, prod);
        if (full) begin
            check32({tag, "_done_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
            check32({tag, "_done_alu_en"},   {31'd0, bus.alu_en},   32'd0);
            check32({tag, "_done_alu_a"},    bus.alu_a,             32'd0);
        end
        bus.out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            check32({tag, "_stall_valid"},  {31'd0, bus.out_valid}, 32'd1);
            check32({tag, "_stall_result"}, bus.result,             prod);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        check32({tag, "_ret_in_ready"},  {31'd0, bus.in_ready},  32'd1);
        check32({tag, "_ret_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        int          k;
        logic [31:0] ra;
        logic [31:0] rb;
        n_checks      = 0;
        n_fails       = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        run_op(32'd6,          32'd7,          0, 1'b0, 1'b1, "basic");
        run_op(32'hDEAD_BEEF,  32'd0,          0, 1'b0, 1'b1, "zero_b");
        run_op(32'hFFFF_FFFF,  32'hFFFF_FFFF,  0, 1'b0, 1'b1, "worst");
        run_op(32'h8000_0000,  32'd2,          0, 1'b0, 1'b1, "wrap");
        run_op(32'h0000_1234,  32'h0000_0010,  10, 1'b1, 1'b1, "bp");
        check32("bp_expected_product", 32'h0001_2340, 32'h0000_1234 * 32'h0000_0010);

        // abandon a long run during a SHIFT cycle
        bus.start = 1'b1;
        bus.op_a  = 32'h1234_5678;
        bus.op_b  = 32'h0000_FFFF;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while (bus.alu_ctrl !== 3'b001 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check32("midop_reached_shift", {29'd0, bus.alu_ctrl}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midop_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'd3, 32'd5, 0, 1'b0, 1'b1, "after_reset");

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run_op(ra, rb, $urandom_range(0, 3), ($urandom_range(0, 7) == 0), 1'b0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
